pc_sequencer: RTL and testbench

Multi-hart program counter sequencer for the single-cycle core. It holds one PC register per hardware thread and selects one enabled hart per cycle in round-robin order. It drives that hart's PC to instruction fetch and updates it from the trap, redirect or sequential next-PC. It sits in front of instruction memory and replaces the single-thread PC register when `NUM_HARTS > 1`. With `NUM_HARTS = 1` it also adds a reset vector, stall, trap and misalignment handling.

---
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Multi-hart program counter sequencer. Holds one PC per hardware thread and
// issues one enabled hart per cycle in round-robin order. The issued hart's
// PC is presented to instruction fetch. On an issue cycle, that PC is updated
// from the trap vector, a redirect target, or the sequential next PC.
//
// Parameters
//   DATA_WIDTH    width of every PC and target
//   NUM_HARTS     number of hardware threads (>= 1, any value)
//   RESET_VECTOR  PC loaded into every hart on reset (truncated to DATA_WIDTH)
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_stall        global stall: freezes all PCs and the hart pointer
//   i_hart_en      per-hart run enable (bit h = hart h eligible)
//   i_redirect     branch/jump taken for the issued hart
//   i_redirect_pc  branch/jump target
//   i_trap         trap raised by the issued instruction
//   i_trap_vector  trap handler address
//   o_pc           PC of the issued hart (registered)
//   o_hart_id      index of the issued hart (registered)
//   o_valid        issued slot is real (combinational)
//   o_misaligned   misaligned redirect on an issued slot (combinational)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int          DATA_WIDTH   = 64,
  parameter int          NUM_HARTS    = 4,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  localparam int         HID_W        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic [NUM_HARTS-1:0]  i_hart_en,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  input  logic                  i_trap,
  input  logic [DATA_WIDTH-1:0] i_trap_vector,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [HID_W-1:0]      o_hart_id,
  output logic                  o_valid,
  output logic                  o_misaligned
);

  // One extra bit so that cur + k (k <= NUM_HARTS) never overflows before
  // the single conditional subtract that performs the modulo.
  localparam int               PTR_W     = HID_W + 1;
  localparam logic [PTR_W-1:0] HART_CNT  = PTR_W'(NUM_HARTS);
  localparam logic [DATA_WIDTH-1:0] RST_PC = RESET_VECTOR[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] pc_q [NUM_HARTS];
  logic [DATA_WIDTH-1:0] pc_d [NUM_HARTS];
  logic [HID_W-1:0]      cur_q;
  logic [HID_W-1:0]      cur_d;
  logic [PTR_W-1:0]      cand;
  logic                  redirect_misaligned;

  // Outputs straight from registers: no combinational path from inputs.
  assign o_pc      = pc_q[cur_q];
  assign o_hart_id = cur_q;

  assign o_valid             = i_hart_en[cur_q] & ~i_stall;
  assign redirect_misaligned = i_redirect & ~i_trap & (i_redirect_pc[1:0] != 2'b00);
  assign o_misaligned        = o_valid & redirect_misaligned;

  // Round-robin pointer: search cur+1 .. cur+NUM_HARTS (cur itself last).
  // Walking k downward and overwriting leaves the nearest enabled hart, so
  // no early exit is needed. With NUM_HARTS = 1 every candidate is 0.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    cur_d = cur_q;
    cand  = '0;
    if (!i_stall) begin
      for (int k = NUM_HARTS; k >= 1; k--) begin
        cand = {1'b0, cur_q} + PTR_W'(k);
        if (cand >= HART_CNT) cand = cand - HART_CNT;
        if (i_hart_en[cand[HID_W-1:0]]) cur_d = cand[HID_W-1:0];
      end
    end
  end

  // Only the issued hart's PC may change; targets are loaded verbatim.
  always_comb begin
    pc_d = pc_q;
    if (o_valid) begin
      if (i_trap || redirect_misaligned) begin
        pc_d[cur_q] = i_trap_vector;
      end else if (i_redirect) begin
        pc_d[cur_q] = i_redirect_pc;
      end else begin
        pc_d[cur_q] = pc_q[cur_q] + DATA_WIDTH'(4);
      end
    end
  end

  // NOTE: the PC file is small and every entry must start at the reset
  // vector, so unlike a RAM it is deliberately reset entry by entry.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      for (int h = 0; h < NUM_HARTS; h++) pc_q[h] <= RST_PC;
      cur_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cur_q <= cur_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer (DATA_WIDTH=64, NUM_HARTS=4,
// RESET_VECTOR=0x1000). A behavioural model (array of PCs plus a pointer
// advanced by modular search) predicts every output each cycle. Directed
// scenarios come first, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int          DW = 64;
  localparam int          NH = 4;
  localparam logic [63:0] RV = 64'h1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic [NH-1:0] hart_en;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          trap;
  logic [DW-1:0] trap_vector;
  logic [DW-1:0] o_pc;
  logic [1:0]    o_hart_id;
  logic          o_valid;
  logic          o_misaligned;

  always #5 clk = ~clk;

  pc_sequencer #(
    .DATA_WIDTH  (DW),
    .NUM_HARTS   (NH),
    .RESET_VECTOR(RV)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_hart_en    (hart_en),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_trap       (trap),
    .i_trap_vector(trap_vector),
    .o_pc         (o_pc),
    .o_hart_id    (o_hart_id),
    .o_valid      (o_valid),
    .o_misaligned (o_misaligned)
  );

  // Reference state.
  longint unsigned m_pc [NH];
  int              m_cur;
  bit              m_known = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic r_n, input logic st, input logic [NH-1:0] en,
                      input logic rd, input logic [63:0] rpc,
                      input logic tr, input logic [63:0] tv);
    bit exp_valid;
    bit exp_mis;
    int nxt;
    @(negedge clk);
    rst_n = r_n; stall = st; hart_en = en;
    redirect = rd; redirect_pc = rpc; trap = tr; trap_vector = tv;
    #1;
    exp_valid = en[m_cur] && !st;
    exp_mis   = exp_valid && rd && !tr && (rpc % 4 != 0);
    if (m_known) begin
      check("pc",         o_pc,         m_pc[m_cur]);
      check("hart_id",    o_hart_id,    64'(m_cur));
      check("valid",      o_valid,      64'(exp_valid));
      check("misaligned", o_misaligned, 64'(exp_mis));
    end
    @(posedge clk);
    if (!r_n) begin
      for (int h = 0; h < NH; h++) m_pc[h] = RV;
      m_cur   = 0;
      m_known = 1'b1;
    end else if (!st) begin
      if (exp_valid) begin
        if (tr)           m_pc[m_cur] = tv;
        else if (rd)      m_pc[m_cur] = (rpc % 4 != 0) ? tv : rpc;
        else              m_pc[m_cur] = m_pc[m_cur] + 4;
      end
      nxt = m_cur;
      for (int d = NH; d >= 1; d--) if (en[(m_cur + d) % NH]) nxt = (m_cur + d) % NH;
      m_cur = nxt;
    end
  endtask

  task automatic run(input logic [NH-1:0] en);
    step(1'b1, 1'b0, en, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'hF, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  // Advance (all harts enabled) until the model points at hart h.
  task automatic goto_hart(input int h);
    for (int i = 0; i < NH + 1 && m_cur != h; i++) run(4'hF);
    #1 check("goto_hart", o_hart_id, 64'(h));
  endtask

  initial begin
    logic [NH-1:0]   en;
    logic [63:0]     rpc;
    logic [63:0]     tv;

    // ---- Reset and sequencing ----
    reset_cycles(2);
    for (int i = 0; i < 4; i++) run(4'hF);
    #1;
    check("seq_pc_after_round",   o_pc,      64'h1004);
    check("seq_hart_after_round", o_hart_id, 64'd0);

    // ---- Priority: trap beats aligned redirect ----
    goto_hart(2);
    step(1'b1, 1'b0, 4'hF, 1'b1, 64'h2000, 1'b1, 64'h8000);
    goto_hart(2);
    check("trap_over_redirect", o_pc, 64'h8000);
    // Misaligned redirect traps to the vector.
    step(1'b1, 1'b0, 4'hF, 1'b1, 64'h2002, 1'b0, 64'h8000);
    goto_hart(2);
    check("misaligned_to_vector", o_pc, 64'h8000);
    // Aligned redirect loads its target.
    step(1'b1, 1'b0, 4'hF, 1'b1, 64'h3000, 1'b0, 64'h8000);
    goto_hart(2);
    check("aligned_redirect", o_pc, 64'h3000);

    // ---- Enable mask ----
    reset_cycles(1);
    for (int i = 0; i < 5; i++) run(4'b1010);
    for (int i = 0; i < 3; i++) run(4'b1000);
    #1 check("sole_hart3", o_hart_id, 64'd3);
    for (int i = 0; i < 3; i++) run(4'b0000);
    #1 check("none_enabled_hold", o_hart_id, 64'd3);

    // ---- Stall with a redirect applied ----
    reset_cycles(1);
    for (int i = 0; i < 6; i++) run(4'hF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF, 1'b1, 64'h4000, 1'b1, 64'h9000);
    #1 check("stall_hold_hart", o_hart_id, 64'd2);
    for (int i = 0; i < 8; i++) run(4'hF);

    // ---- Wrap-around ----
    goto_hart(1);
    step(1'b1, 1'b0, 4'hF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
    goto_hart(1);
    check("wrap_target", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    run(4'hF);
    goto_hart(1);
    check("wrap_to_zero", o_pc, 64'h0);

    // ---- Synchronous reset mid-run with a trap ----
    run(4'hF);
    step(1'b0, 1'b0, 4'hF, 1'b0, 64'h0, 1'b1, 64'h7000);
    #1;
    check("mid_reset_pc",   o_pc,      RV);
    check("mid_reset_hart", o_hart_id, 64'd0);
    for (int i = 0; i < 5; i++) run(4'hF);

    // ---- Randomized run ----
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 3) == 0) ? NH'($urandom) : 4'hF;
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      tv  = {$urandom, $urandom};
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 7) == 0),
           en,
           ($urandom_range(0, 3) == 0), rpc,
           ($urandom_range(0, 7) == 0), tv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
